// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
//   arb_state_t : controller states (IDLE, INST, DATA, RESP)
//   arb_owner_t : which requester owns the port (OWN_INST, OWN_DATA)
//   owner_mask  : helper that decodes an owner into a one-hot request slot
package arb_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    // OWN_INST encodes as 0 so the owner flop resets to the fetch side.
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    // Bit 0 is the fetch slot, bit 1 the data slot.
    function automatic logic [1:0] owner_mask(input arb_owner_t who);
        return (who == OWN_INST) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin grant logic (purely combinational).
//   req[1:0]    : pending requests, bit 0 = fetch, bit 1 = data
//   last_grant  : owner of the most recent grant
//   grant_valid : at least one request is pending
//   grant       : selected owner; meaningful only when grant_valid=1
module rr_arbiter2
    import arb_types::*;
(
    input  logic [1:0] req,
    input  arb_owner_t last_grant,
    output logic       grant_valid,
    output arb_owner_t grant
);

    always_comb begin
        // NOTE: every output gets a default before any branch, otherwise an
        // uncovered path would infer a latch.
        grant_valid = |req;
        grant       = OWN_INST;
        if (req == 2'b11) begin
            // Contention: hand the port to whoever did not have it last.
            grant = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (req[1]) begin
            grant = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data requesters.
// A granted request is latched into the mem_* registers, held until the
// downstream mem_resp, and the result is returned to the owner as a one-cycle
// resp pulse. Contention is resolved round-robin.
//   clk, rst                : clock, asynchronous active-high reset
//   inst_read/inst_addr     : fetch request (held until inst_resp)
//   inst_resp/inst_rdata    : fetch completion pulse and word
//   data_read/data_write    : data request (held until data_resp); write wins
//   data_mbe/addr/wdata     : data byte enables, address, write data
//   data_resp/data_rdata    : data completion pulse and load word
//   mem_read/write/addr/... : registered downstream request
//   mem_resp/mem_rdata      : downstream completion pulse and read data
//   busy                    : controller is not in IDLE
module mem_port_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MBE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_read,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_resp,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_read,
    input  logic              data_write,
    input  logic [MBE_W-1:0]  data_mbe,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_resp,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MBE_W-1:0]  mem_mbe,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last_grant;

    logic [1:0] req;
    logic       grant_valid;
    arb_owner_t grant;

    assign req = {data_read | data_write, inst_read};

    rr_arbiter2 u_rr (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            last_grant <= OWN_DATA;
            inst_resp  <= 1'b0;
            inst_rdata <= '0;
            data_resp  <= 1'b0;
            data_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mbe    <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            // resp is a pulse: cleared every cycle unless set below.
            inst_resp <= 1'b0;
            data_resp <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        if (grant == OWN_INST) begin
                            state     <= INST;
                            mem_addr  <= inst_addr;
                            mem_wdata <= '0;
                            mem_mbe   <= '1;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end else begin
                            state     <= DATA;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata;
                            mem_mbe   <= data_mbe;
                            // A simultaneous read+write is treated as a write.
                            mem_write <= data_write;
                            mem_read  <= data_read & ~data_write;
                        end
                    end
                end

                INST, DATA: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RESP;
                        if (owner == OWN_INST) begin
                            inst_rdata <= mem_rdata;
                            inst_resp  <= 1'b1;
                        end else begin
                            data_rdata <= mem_rdata;
                            data_resp  <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MBE_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_read;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_resp;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_read;
    logic              data_write;
    logic [MBE_W-1:0]  data_mbe;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_resp;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MBE_W-1:0]  mem_mbe;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MBE_W(MBE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_read  (inst_read),
        .inst_addr  (inst_addr),
        .inst_resp  (inst_resp),
        .inst_rdata (inst_rdata),
        .data_read  (data_read),
        .data_write (data_write),
        .data_mbe   (data_mbe),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_resp  (data_resp),
        .data_rdata (data_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mbe    (mem_mbe),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a sample where the mem op is visible: wait n_wait cycles, then
    // respond for one cycle. Returns at the RESP-cycle sample point.
    task automatic complete(input int n_wait, input logic [DATA_W-1:0] rd);
        repeat (n_wait) tick();
        mem_resp  = 1'b1;
        mem_rdata = rd;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        inst_read  = 1'b0;
        inst_addr  = '0;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_mbe   = '0;
        data_addr  = '0;
        data_wdata = '0;
        mem_resp   = 1'b0;
        mem_rdata  = '0;

        // Reset state
        repeat (2) tick();
        check("rst_busy",      busy,      0);
        check("rst_mem_read",  mem_read,  0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_inst_resp", inst_resp, 0);
        check("rst_data_resp", data_resp, 0);
        check("rst_inst_rd",   inst_rdata, 0);
        rst = 1'b0;
        tick();

        // Inst-only read, memory answers 2 cycles after mem_read
        inst_read = 1'b1;
        inst_addr = 32'h0000_0060;
        tick();
        check("i_mem_read",  mem_read,  1);
        check("i_mem_write", mem_write, 0);
        check("i_mem_addr",  mem_addr,  32'h60);
        check("i_mem_mbe",   mem_mbe,   4'hF);
        check("i_busy",      busy,      1);
        check("i_no_resp_early", inst_resp, 0);
        complete(2, 32'h00A0_0093);
        check("i_resp",      inst_resp,  1);
        check("i_rdata",     inst_rdata, 32'h00A0_0093);
        check("i_data_resp", data_resp,  0);
        check("i_mem_read_clr", mem_read, 0);
        inst_read = 1'b0;
        tick();
        check("i_resp_once", inst_resp, 0);
        check("i_idle_busy", busy,      0);

        // Data write
        data_write = 1'b1;
        data_addr  = 32'h100;
        data_wdata = 32'hDEAD_BEEF;
        data_mbe   = 4'b0011;
        tick();
        check("w_mem_write", mem_write, 1);
        check("w_mem_read",  mem_read,  0);
        check("w_mem_addr",  mem_addr,  32'h100);
        check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("w_mem_mbe",   mem_mbe,   4'b0011);
        tick();
        check("w_mem_read_hold", mem_read, 0);
        complete(0, '0);
        check("w_resp",      data_resp, 1);
        check("w_inst_resp", inst_resp, 0);
        check("w_mem_write_clr", mem_write, 0);
        data_write = 1'b0;
        tick();
        check("w_resp_once", data_resp, 0);

        // Stability: address change after grant is ignored
        data_read = 1'b1;
        data_addr = 32'h100;
        data_mbe  = 4'hF;
        tick();
        check("s_mem_read", mem_read, 1);
        check("s_addr0",    mem_addr, 32'h100);
        data_addr = 32'h200;
        tick();
        check("s_addr1",    mem_addr, 32'h100);
        mem_resp  = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        check("s_addr_resp_cycle", mem_addr, 32'h100);
        tick();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        check("s_resp",       data_resp,  1);
        check("s_rdata",      data_rdata, 32'h1234_5678);
        check("s_inst_rd_hold", inst_rdata, 32'h00A0_0093);
        data_read = 1'b0;
        tick();

        // Contention after reset: I, D, I, D
        do_reset();
        inst_addr = 32'h0000_1000;
        data_addr = 32'h0000_2000;
        inst_read = 1'b1;
        data_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_data;
            exp_data = k[0];
            tick();
            check($sformatf("c%0d_addr", k), mem_addr, exp_data ? 32'h2000 : 32'h1000);
            check($sformatf("c%0d_read", k), mem_read, 1);
            complete(0, 32'hA000_0000 + 32'(k));
            check($sformatf("c%0d_inst_resp", k), inst_resp, !exp_data);
            check($sformatf("c%0d_data_resp", k), data_resp, exp_data);
            if (exp_data) begin
                check($sformatf("c%0d_rdata", k), data_rdata, 32'hA000_0000 + 32'(k));
                data_read = 1'b0;
            end else begin
                check($sformatf("c%0d_rdata", k), inst_rdata, 32'hA000_0000 + 32'(k));
                inst_read = 1'b0;
            end
            tick();
            check($sformatf("c%0d_idle", k), busy, 0);
            if (k < 3) begin
                inst_read = 1'b1;
                data_read = 1'b1;
            end else begin
                inst_read = 1'b0;
                data_read = 1'b0;
            end
        end
        tick();

        // Reset in the middle of an INST transaction
        inst_read = 1'b1;
        inst_addr = 32'h0000_0300;
        tick();
        check("r_mem_read_pre", mem_read, 1);
        tick();
        rst = 1'b1;
        #1;
        check("r_mem_read_async", mem_read, 0);
        check("r_busy_async",     busy,     0);
        inst_read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mem_resp  = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        check("r_no_resp", inst_resp, 0);
        check("r_busy",    busy,      0);
        check("r_rdata",   inst_rdata, 0);
        tick();
        check("r_no_resp2", inst_resp, 0);
        check("r_busy2",    busy,      0);

        // Read+write together: write wins
        data_read  = 1'b1;
        data_write = 1'b1;
        data_addr  = 32'h0000_0400;
        data_wdata = 32'hCAFE_F00D;
        data_mbe   = 4'b1100;
        tick();
        check("rw_mem_write", mem_write, 1);
        check("rw_mem_read",  mem_read,  0);
        check("rw_mem_mbe",   mem_mbe,   4'b1100);
        complete(1, '0);
        check("rw_resp", data_resp, 1);
        data_read  = 1'b0;
        data_write = 1'b0;
        tick();

        // Spurious mem_resp while idle
        mem_resp  = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        check("sp_data_resp", data_resp, 0);
        check("sp_inst_resp", inst_resp, 0);
        check("sp_busy",      busy,      0);
        tick();
        check("sp_data_resp2", data_resp, 0);
        check("sp_inst_resp2", inst_resp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
